commit_tracker: RTL

COMMIT_TRACKER -- requirements
Module: commit_tracker

---
 rtl/commit_tracker_pkg.sv | 15 +
 rtl/commit_tracker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/commit_tracker_pkg.sv
// Shared definitions for the commit tracker: trap encoding, GPR index width
// and the run/drain/halt state encoding.
package commit_tracker_pkg;

  localparam logic [31:0] TRAP_INST_DEF = 32'h0000_006b;
  localparam int          GPR_IDX_W     = 5;
  localparam int          COMMIT_DEST_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/commit_tracker.sv
// Registers one retired instruction per cycle into a commit record, detects the
// simulation trap, pulses the trap event once and then halts the core.
module commit_tracker
  import commit_tracker_pkg::*;
#(
  parameter int          XLEN      = 64,
  parameter logic [31:0] TRAP_INST = TRAP_INST_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [31:0]              wb_inst,
  input  logic                     wb_wen,
  input  logic [GPR_IDX_W-1:0]     wb_wdest,
  input  logic [XLEN-1:0]          wb_wdata,
  input  logic                     wb_mmio,
  input  logic [XLEN-1:0]          wb_a0,
  output logic                     commit_valid,
  output logic [XLEN-1:0]          commit_pc,
  output logic [31:0]              commit_instr,
  output logic                     commit_wen,
  output logic [COMMIT_DEST_W-1:0] commit_wdest,
  output logic [XLEN-1:0]          commit_wdata,
  output logic                     commit_skip,
  output logic                     trap_valid,
  output logic [2:0]               trap_code,
  output logic [XLEN-1:0]          trap_pc,
  output logic [XLEN-1:0]          cycle_cnt,
  output logic [XLEN-1:0]          instr_cnt,
  output logic                     halted
);

  // state | meaning
  // RUN   | accepting writeback, committing one record per wb_valid
  // DRAIN | trap retired last cycle; trap_valid high for this one cycle
  // HALT  | absorbing until reset; wb_valid ignored, cycle_cnt frozen
  state_e state_q, state_d;

  logic                     accept;
  logic                     is_trap;
  logic                     cv_q, cv_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [31:0]              inst_q, inst_d;
  logic                     wen_q, wen_d;
  logic [COMMIT_DEST_W-1:0] wdest_q, wdest_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic                     skip_q, skip_d;
  logic [2:0]               tcode_q, tcode_d;
  logic [XLEN-1:0]          tpc_q, tpc_d;
  logic [XLEN-1:0]          ccnt_q, ccnt_d;
  logic [XLEN-1:0]          icnt_q, icnt_d;
  logic                     unused_a0;

  assign unused_a0 = ^wb_a0[XLEN-1:3];
  assign is_trap   = wb_inst == TRAP_INST;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (wb_valid && is_trap) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    accept     = wb_valid && (state_q == ST_RUN);
    trap_valid = state_q == ST_DRAIN;
    halted     = state_q == ST_HALT;
  end

  // Commit fields only load on an accepted retirement, so they hold otherwise.
  always_comb begin
    cv_d    = accept;
    pc_d    = pc_q;
    inst_d  = inst_q;
    wen_d   = wen_q;
    wdest_d = wdest_q;
    wdata_d = wdata_q;
    skip_d  = skip_q;
    tcode_d = tcode_q;
    tpc_d   = tpc_q;
    ccnt_d  = (state_q != ST_HALT) ? ccnt_q + XLEN'(1) : ccnt_q;
    icnt_d  = accept ? icnt_q + XLEN'(1) : icnt_q;
    if (accept) begin
      pc_d    = wb_pc;
      inst_d  = wb_inst;
      wen_d   = wb_wen && (wb_wdest != '0);
      wdest_d = {{(COMMIT_DEST_W-GPR_IDX_W){1'b0}}, wb_wdest};
      wdata_d = wb_wdata;
      skip_d  = wb_mmio;
      if (is_trap) begin
        tcode_d = wb_a0[2:0];
        tpc_d   = wb_pc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cv_q    <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      wen_q   <= 1'b0;
      wdest_q <= '0;
      wdata_q <= '0;
      skip_q  <= 1'b0;
      tcode_q <= '0;
      tpc_q   <= '0;
      ccnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      cv_q    <= cv_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      wen_q   <= wen_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
      skip_q  <= skip_d;
      tcode_q <= tcode_d;
      tpc_q   <= tpc_d;
      ccnt_q  <= ccnt_d;
      icnt_q  <= icnt_d;
    end
  end

  assign commit_valid = cv_q;
  assign commit_pc    = pc_q;
  assign commit_instr = inst_q;
  assign commit_wen   = wen_q;
  assign commit_wdest = wdest_q;
  assign commit_wdata = wdata_q;
  assign commit_skip  = skip_q;
  assign trap_code    = tcode_q;
  assign trap_pc      = tpc_q;
  assign cycle_cnt    = ccnt_q;
  assign instr_cnt    = icnt_q;

endmodule
